wb_register_file: RTL

- Architectural register file for the pipelined MIPS core. It is the consumer of the write-back stage's ResultW / WriteRegW / RegWriteW triple.
- Provides two decode-stage read ports with same-cycle write-through bypass, so the decode stage sees a value written back in the same cycle.
- Also provides a non-bypassed debug read port and a committed-write counter for bench observability.

---
 rtl/wb_register_file.sv | 85 ++++++++
 1 files changed

// File: rtl/wb_register_file.sv
// Architectural register file for the pipelined MIPS core.
// It takes the write-back stage's ResultW / WriteRegW / RegWriteW triple.
// Two decode read ports have write-through bypass, so a value being written
// back this cycle is visible to decode in the same cycle.
// The debug read port shows committed state only and never bypasses.
// WrCount counts committed writes since reset and wraps.
// Register 0 is hardwired to zero.
module wb_register_file #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int CNT_W  = 32
) (
  input  logic              Clk,
  input  logic              rst,
  input  logic              RegWriteW,
  input  logic [ADDR_W-1:0] WriteRegW,
  input  logic [DATA_W-1:0] ResultW,
  input  logic [ADDR_W-1:0] A1,
  input  logic [ADDR_W-1:0] A2,
  output logic [DATA_W-1:0] RD1,
  output logic [DATA_W-1:0] RD2,
  input  logic [ADDR_W-1:0] DbgAddr,
  output logic [DATA_W-1:0] DbgData,
  output logic [CNT_W-1:0]  WrCount
);

  localparam int NREG = 2 ** ADDR_W;

  // Entry 0 is cleared by reset and never written, so it always reads zero.
  logic [DATA_W-1:0] regs [NREG];
  logic [CNT_W-1:0]  wr_count;
  logic              commit;

  // A write to register 0 is dropped and is not counted.
  assign commit = RegWriteW && (WriteRegW != '0);

  // Register storage: asynchronous clear, one write per committed cycle.
  always_ff @(posedge Clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NREG; i++) begin
        regs[i] <= '0;
      end
    end else begin
      for (int i = 1; i < NREG; i++) begin
        if (commit && (WriteRegW == ADDR_W'(i))) begin
          regs[i] <= ResultW;
        end
      end
    end
  end

  // Committed-write counter; it wraps modulo 2**CNT_W.
  always_ff @(posedge Clk or negedge rst) begin
    if (!rst) begin
      wr_count <= '0;
    end else if (commit) begin
      wr_count <= wr_count + CNT_W'(1);
    end
  end

  assign WrCount = wr_count;

  // Decode read ports: zero for address 0 or reset, otherwise bypass before storage.
  always_comb begin
    RD1 = '0;
    RD2 = '0;
    if (rst) begin
      if (A1 != '0) begin
        RD1 = (RegWriteW && (WriteRegW == A1)) ? ResultW : regs[A1];
      end
      if (A2 != '0) begin
        RD2 = (RegWriteW && (WriteRegW == A2)) ? ResultW : regs[A2];
      end
    end
  end

  // Debug read port: committed state only, forced to zero during reset.
  always_comb begin
    DbgData = '0;
    if (rst) begin
      DbgData = regs[DbgAddr];
    end
  end

endmodule
